axi_traffic_gen: RTL

// - AXI4 master traffic generator: the upstream stage that drives the AXI bus observed by
//   axi_spyblock and served by the bench slave.
// - Per transaction: one INCR write burst (AW, W beats, B), then a read burst (AR, R beats)
//   to the same address. Runs NUM_TXN transactions per start, then reports done and error count.

---
 rtl/axi_traffic_gen.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_traffic_gen.sv
// AXI4 master that issues NUM_TXN write-then-read INCR bursts per start and counts bad responses.
// Optional build macro AXI_TGEN_RDCHECK_EN: compare read data and rlast position against the write pattern.
module axi_traffic_gen #(
  parameter int unsigned            ID_WIDTH   = 4,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 'h1000,
  parameter int unsigned            BURST_LEN  = 3,
  parameter int unsigned            NUM_TXN    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               err_cnt_o,
  output logic [ID_WIDTH-1:0]       awid_o,
  output logic [ADDR_WIDTH-1:0]     awaddr_o,
  output logic [7:0]                awlen_o,
  output logic [2:0]                awsize_o,
  output logic [1:0]                awburst_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/8-1:0]   wstrb_o,
  output logic                      wlast_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  input  logic [ID_WIDTH-1:0]       bid_i,
  input  logic [1:0]                bresp_i,
  input  logic                      bvalid_i,
  output logic                      bready_o,
  output logic [ID_WIDTH-1:0]       arid_o,
  output logic [ADDR_WIDTH-1:0]     araddr_o,
  output logic [7:0]                arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  input  logic [ID_WIDTH-1:0]       rid_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  input  logic                      rvalid_i,
  output logic                      rready_o
);

  // state  | meaning
  // S_IDLE | waiting for start after reset
  // S_AW   | write address offered, waiting for awready
  // S_W    | streaming write beats; also collecting the write response
  // S_AR   | read address offered, waiting for arready
  // S_R    | accepting read beats until rlast
  // S_DONE | run complete, results held until the next start
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_AR, S_R, S_DONE} state_e;

  localparam int unsigned          STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned          EXT_W    = ADDR_WIDTH + 32;
  localparam logic [2:0]           AXSIZE   = 3'($clog2(STRB_W));
  localparam logic [7:0]           LEN      = 8'(BURST_LEN);
  localparam logic [15:0]          LAST_TXN = 16'(NUM_TXN - 1);
  localparam logic [EXT_W-1:0]     STRIDE   = EXT_W'((BURST_LEN + 1) * STRB_W);

  state_e                 state_q;
  logic [15:0]            txn_idx_q;
  logic [7:0]             beat_q;
  logic                   b_seen_q;
  logic                   w_done_q;
  logic [15:0]            err_cnt_q;
  logic                   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                   busy_q, done_q;

  logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                   beat_last;
  logic [EXT_W-1:0]       addr_ext;
  logic [DATA_WIDTH-1:0]  pattern;
  logic                   b_err, r_resp_err, r_data_err, r_last_err;
  logic [2:0]             err_inc;
  logic [16:0]            err_sum;
  logic [15:0]            err_d;

  assign aw_hs     = awvalid_q & awready_i;
  assign w_hs      = wvalid_q & wready_i;
  assign b_hs      = bready_q & bvalid_i;
  assign ar_hs     = arvalid_q & arready_i;
  assign r_hs      = rready_q & rvalid_i;
  assign beat_last = (beat_q == LEN);

  // Address arithmetic is done wide and truncated so large strides wrap like the bus would.
  assign addr_ext = EXT_W'(BASE_ADDR) + EXT_W'(txn_idx_q) * STRIDE;
  assign pattern  = DATA_WIDTH'({txn_idx_q, beat_q});

  assign b_err      = b_hs && (bresp_i != 2'b00);
  assign r_resp_err = r_hs && (rresp_i != 2'b00);
`ifdef AXI_TGEN_RDCHECK_EN
  assign r_data_err = r_hs && (rdata_i != pattern);
  assign r_last_err = r_hs && (rlast_i != beat_last);
`else
  assign r_data_err = 1'b0;
  assign r_last_err = 1'b0;
  logic unused_rd;
  assign unused_rd = ^{rdata_i, pattern};
`endif

  assign err_inc = 3'(b_err) + 3'(r_resp_err) + 3'(r_data_err) + 3'(r_last_err);
  assign err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  logic unused_in;
  assign unused_in = ^{bid_i, rid_i, addr_ext[EXT_W-1:ADDR_WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      txn_idx_q <= '0;
      beat_q    <= '0;
      b_seen_q  <= 1'b0;
      w_done_q  <= 1'b0;
      err_cnt_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q   <= S_AW;
            txn_idx_q <= '0;
            beat_q    <= '0;
            err_cnt_q <= '0;
            awvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            state_q   <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (beat_last) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
          if (b_hs) begin
            bready_q <= 1'b0;
            b_seen_q <= 1'b1;
          end
          // B and the last W beat may complete in either order, or together.
          if ((w_done_q || (w_hs && beat_last)) && (b_seen_q || b_hs)) begin
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
            beat_q    <= '0;
            w_done_q  <= 1'b0;
            b_seen_q  <= 1'b0;
          end
        end
        S_AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            if (rlast_i) begin
              rready_q <= 1'b0;
              beat_q   <= '0;
              if (txn_idx_q == LAST_TXN) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                txn_idx_q <= txn_idx_q + 16'd1;
                awvalid_q <= 1'b1;
                state_q   <= S_AW;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_cnt_o = err_cnt_q;

  assign awid_o    = txn_idx_q[ID_WIDTH-1:0];
  assign awaddr_o  = addr_ext[ADDR_WIDTH-1:0];
  assign awlen_o   = LEN;
  assign awsize_o  = AXSIZE;
  assign awburst_o = 2'b01;
  assign awvalid_o = awvalid_q;

  assign wdata_o   = pattern;
  assign wstrb_o   = '1;
  assign wlast_o   = wvalid_q & beat_last;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

  assign arid_o    = txn_idx_q[ID_WIDTH-1:0];
  assign araddr_o  = addr_ext[ADDR_WIDTH-1:0];
  assign arlen_o   = LEN;
  assign arsize_o  = AXSIZE;
  assign arburst_o = 2'b01;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule
